except_commit: RTL

- Sits between the MEM stage and cp0, registering the MEM-to-WB boundary.
- Collects per-instruction exception flags and samples the pending-interrupt condition from cp0 state.
- Prioritises these into a single exception, then drives cp0's wb_except/wb_excode/wb_bd/wb_pc/wb_badvaddr/eret_flush inputs.
- Holds a redirect request to fetch until it is acknowledged, squashing wrong-path instructions meanwhile.

---
 rtl/except_commit_if.sv | 52 +++++
 rtl/except_commit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/except_commit_if.sv
//------------------------------------------------------------------------------
// Module      : except_commit_if
// Description : MEM/cp0/fetch-facing signal bundle for except_commit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface except_commit_if;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_bd;
  logic        ms_adel_if;
  logic        ms_ri;
  logic        ms_ov;
  logic        ms_syscall;
  logic        ms_break;
  logic        ms_adel_ld;
  logic        ms_ades;
  logic [31:0] ms_vaddr;
  logic        ms_eret;
  logic [31:0] c0_status;
  logic [31:0] c0_cause;
  logic [31:0] c0_epc;
  logic        wb_except;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic        flush_req;
  logic [31:0] flush_target;
  logic        fs_ack;

  modport master (
    output ms_valid, ms_pc, ms_bd, ms_adel_if, ms_ri, ms_ov, ms_syscall,
           ms_break, ms_adel_ld, ms_ades, ms_vaddr, ms_eret,
           c0_status, c0_cause, c0_epc, fs_ack,
    input  ws_allowin, wb_except, wb_excode, wb_bd, wb_pc, wb_badvaddr,
           eret_flush, flush_req, flush_target
  );

  modport slave (
    input  ms_valid, ms_pc, ms_bd, ms_adel_if, ms_ri, ms_ov, ms_syscall,
           ms_break, ms_adel_ld, ms_ades, ms_vaddr, ms_eret,
           c0_status, c0_cause, c0_epc, fs_ack,
    output ws_allowin, wb_except, wb_excode, wb_bd, wb_pc, wb_badvaddr,
           eret_flush, flush_req, flush_target
  );
endinterface

`default_nettype wire

// File: rtl/except_commit.sv
//------------------------------------------------------------------------------
// Module      : except_commit
// Description : MEM->WB exception prioritisation, cp0 commit and fetch redirect.
//               Optional macro EXC_OVERFLOW_EN enables the overflow exception.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module except_commit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] CR_EPC_RESET = 32'h0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  except_commit_if.slave     bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [1:0] c_TGT_NONE = 2'd0;
  localparam logic [1:0] c_TGT_EXC  = 2'd1;
  localparam logic [1:0] c_TGT_ERET = 2'd2;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;

  logic        w_int_pend;
  logic        w_exc;
  logic [4:0]  w_code;
  logic [31:0] w_bad;
  logic        w_capture;
  logic        w_eret;
  logic        w_unused;

  logic        r_wb_except;
  logic [4:0]  r_wb_excode;
  logic        r_wb_bd;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_badvaddr;
  logic        r_eret_flush;
  logic [1:0]  r_tgt_kind;
  logic [31:0] r_epc_target;

  assign w_int_pend = bus.c0_status[0] & ~bus.c0_status[1]
                    & (|(bus.c0_cause[15:8] & bus.c0_status[15:8]));

  // Priority chain; the first matching source defines excode and badvaddr.
  always_comb begin
    w_exc  = 1'b1;
    w_code = 5'h00;
    w_bad  = 32'h0;
    if (w_int_pend) begin
      w_code = 5'h00;
    end else if (bus.ms_adel_if) begin
      w_code = 5'h04;
      w_bad  = bus.ms_pc;
    end else if (bus.ms_ri) begin
      w_code = 5'h0A;
`ifdef EXC_OVERFLOW_EN
    end else if (bus.ms_ov) begin
      w_code = 5'h0C;
`endif
    end else if (bus.ms_syscall) begin
      w_code = 5'h08;
    end else if (bus.ms_break) begin
      w_code = 5'h09;
    end else if (bus.ms_adel_ld) begin
      w_code = 5'h04;
      w_bad  = bus.ms_vaddr;
    end else if (bus.ms_ades) begin
      w_code = 5'h05;
      w_bad  = bus.ms_vaddr;
    end else begin
      w_exc  = 1'b0;
    end
  end

  assign w_capture = (r_state == S_IDLE) && bus.ms_valid;
  assign w_eret    = bus.ms_eret && !w_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture && (w_exc || w_eret)) w_state_next = S_FLUSH;
      S_FLUSH: if (bus.fs_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ws_allowin = 1'b0;
    bus.flush_req  = 1'b0;
    case (r_state)
      S_IDLE:  bus.ws_allowin = 1'b1;
      S_FLUSH: bus.flush_req  = 1'b1;
      default: bus.ws_allowin = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_except   <= 1'b0;
      r_wb_excode   <= 5'h00;
      r_wb_bd       <= 1'b0;
      r_wb_pc       <= 32'h0;
      r_wb_badvaddr <= 32'h0;
      r_eret_flush  <= 1'b0;
      r_tgt_kind    <= c_TGT_NONE;
      r_epc_target  <= CR_EPC_RESET;
    end else begin
      r_wb_except  <= w_capture && w_exc;
      r_eret_flush <= w_capture && w_eret;
      if (w_capture) begin
        r_wb_excode <= w_code;
        r_wb_bd     <= bus.ms_bd;
        r_wb_pc     <= bus.ms_pc;
        if (w_exc) begin
          r_wb_badvaddr <= w_bad;
          r_tgt_kind    <= c_TGT_EXC;
        end else if (w_eret) begin
          r_tgt_kind    <= c_TGT_ERET;
          r_epc_target  <= bus.c0_epc;
        end
      end
    end
  end

  assign bus.wb_except    = r_wb_except;
  assign bus.wb_excode    = r_wb_excode;
  assign bus.wb_bd        = r_wb_bd;
  assign bus.wb_pc        = r_wb_pc;
  assign bus.wb_badvaddr  = r_wb_badvaddr;
  assign bus.eret_flush   = r_eret_flush;
  assign bus.flush_target = (r_tgt_kind == c_TGT_ERET) ? r_epc_target :
                            (r_tgt_kind == c_TGT_EXC)  ? EXC_VECTOR   : 32'h0;

  // Status/Cause fields outside the interrupt check, and ms_ov when overflow is off.
  assign w_unused = ^{bus.ms_ov, bus.c0_status[31:16], bus.c0_status[7:2],
                      bus.c0_cause[31:16], bus.c0_cause[7:0]};

endmodule

`default_nettype wire
